muldiv_sequencer: RTL

//  Multi-cycle MULT/MULTU/DIV/DIVU engine and its stall controller for mips_cpu_harvard.

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_step.sv | 34 +++
 rtl/muldiv_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the multi-cycle multiply/divide engine.
// Optional feature macro used by this block: MULDIV_EARLY_OUT_EN.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        FIXUP = 2'b10,
        DONE  = 2'b11
    } muldiv_state_t;

    localparam int MULDIV_WIDTH = 32;
    localparam int CNT_W        = $clog2(MULDIV_WIDTH + 1);

    function automatic logic op_is_div(input muldiv_op_t op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input muldiv_op_t op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the engine: shift-add multiply step or restoring-division step.
// acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;
    logic           fits;

    always_comb begin
        sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        // Unsigned compare rather than the borrow bit, so a zero divisor still yields all-ones
        fits  = (trial >= {1'b0, opnd});
        diff  = trial - {1'b0, opnd};
        if (!is_div) begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end else if (fits) begin
            acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// MULT/MULTU/DIV/DIVU sequencer with CPU stall control and {hi,lo} write strobe.
// Define MULDIV_EARLY_OUT_EN to finish multiplies early and skip iteration for divide-by-zero.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             hi_lo_wren,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    muldiv_state_t      state_q, state_d;
    muldiv_op_t         op_in, op_q, op_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               negq_q, negq_d, negr_q, negr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               run_last;
    logic               early_mul;
    logic               skip_run;
    logic [WIDTH-1:0]   mplier_left;

    assign op_in = muldiv_op_t'(op);
    assign a_mag = (op_is_signed(op_in) && operand_a[WIDTH-1]) ? -operand_a : operand_a;
    assign b_mag = (op_is_signed(op_in) && operand_b[WIDTH-1]) ? -operand_b : operand_b;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (op_is_div(op_q)),
        .acc     (acc_q),
        .opnd    (opnd_q),
        .acc_next(acc_step)
    );

    // Multiplier bits not yet consumed sit in acc[WIDTH-1-cnt:0]
    assign mplier_left = acc_q[WIDTH-1:0] << cnt_q;
`ifdef MULDIV_EARLY_OUT_EN
    assign early_mul = !op_is_div(op_q) && (mplier_left == '0);
    assign skip_run  = (operand_b == '0);
`else
    assign early_mul = 1'b0;
    assign skip_run  = 1'b0;
`endif
    assign run_last = (cnt_q == CW'(WIDTH - 1)) || early_mul;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else if (clk_enable) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = skip_run ? FIXUP : RUN;
            RUN:     if (run_last) state_d = FIXUP;
            FIXUP:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        hi_lo_wren = done;
        stall      = (start && state_q == IDLE) || (busy && state_q != DONE);
    end

    always_comb begin
        op_d   = op_q;
        acc_d  = acc_q;
        opnd_d = opnd_q;
        negq_d = negq_q;
        negr_d = negr_q;
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    op_d   = op_in;
                    opnd_d = op_is_div(op_in) ? b_mag : a_mag;
                    acc_d  = {{WIDTH{1'b0}}, (op_is_div(op_in) ? a_mag : b_mag)};
                    negq_d = op_is_signed(op_in) && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                    negr_d = op_is_signed(op_in) && operand_a[WIDTH-1];
                    // Skipped divide-by-zero lands on the same values iteration would give
                    if (skip_run && op_is_div(op_in)) acc_d = {a_mag, {WIDTH{1'b1}}};
                end
            end
            RUN: begin
                cnt_d = cnt_q + CW'(1);
                acc_d = early_mul ? (acc_q >> (WIDTH - int'(cnt_q))) : acc_step;
            end
            FIXUP: begin
                if (!op_is_div(op_q)) begin
                    {hi_d, lo_d} = negq_q ? -acc_q : acc_q;
                end else begin
                    lo_d = negq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else if (clk_enable) begin
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (clk_enable) begin
            op_q   <= op_d;
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            negq_q <= negq_d;
            negr_q <= negr_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule
